// File: rtl/bcd_bin_codec.sv
// Bidirectional BCD <-> binary converter built around one iterative engine.
// Mode 0 runs reverse double-dabble (BCD -> binary) and mode 1 runs
// double-dabble (binary -> BCD). Each SHIFT cycle processes one bit.
// Each conversion produces a registered BCD/binary result pair and an error flag.
module bcd_bin_codec #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [4*DIGITS-1:0]   bcd_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [BIN_W-1:0]      bin_o
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  // The binary width must be able to hold every decimal value of DIGITS digits.
  if ((64'd1 << BIN_W) < (64'd10 ** DIGITS)) begin : g_bad_width
    $error("bcd_bin_codec: BIN_W too small for DIGITS");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_mode;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   r_work_bcd;
  logic [BIN_W-1:0]   r_work_bin;
  logic               r_ovf;
  logic [BCD_W-1:0]   r_cap_bcd;
  logic [BIN_W-1:0]   r_cap_bin;
  logic [BCD_W-1:0]   r_bcd_o;
  logic [BIN_W-1:0]   r_bin_o;
  logic               r_err;

  logic               w_bad_digit;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_step_bcd;
  logic [BIN_W-1:0]   w_step_bin;
  logic               w_step_out;

  // Flag any operand digit above 9 (only relevant for BCD -> binary requests).
  always_comb begin
    w_bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_i[4*i +: 4] > 4'd9) w_bad_digit = 1'b1;
    end
  end

  // One engine iteration on {bcd, bin} for the captured mode.
  always_comb begin
    w_adj      = r_work_bcd;
    w_step_bcd = '0;
    w_step_bin = '0;
    w_step_out = 1'b0;
    if (!r_mode) begin
      // Shift right first, then pull every digit that reached >= 8 back by 3.
      w_step_bin = {r_work_bcd[0], r_work_bin[BIN_W-1:1]};
      w_step_bcd = {1'b0, r_work_bcd[BCD_W-1:1]};
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (w_step_bcd[4*i +: 4] >= 4'd8) w_step_bcd[4*i +: 4] = w_step_bcd[4*i +: 4] - 4'd3;
      end
    end else begin
      // Add 3 to every digit >= 5, then shift left; the bcd MSB falls out as overflow.
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (w_adj[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = w_adj[4*i +: 4] + 4'd3;
      end
      w_step_out = w_adj[BCD_W-1];
      w_step_bcd = {w_adj[BCD_W-2:0], r_work_bin[BIN_W-1]};
      w_step_bin = {r_work_bin[BIN_W-2:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_state_nxt = (!mode_i && w_bad_digit) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        if (r_cnt == '0) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, iteration, and result loading.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_mode     <= 1'b0;
      r_cnt      <= '0;
      r_work_bcd <= '0;
      r_work_bin <= '0;
      r_ovf      <= 1'b0;
      r_cap_bcd  <= '0;
      r_cap_bin  <= '0;
      r_bcd_o    <= '0;
      r_bin_o    <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_mode    <= mode_i;
            r_cap_bcd <= bcd_i;
            r_cap_bin <= bin_i;
            r_cnt     <= CNT_W'(BIN_W - 1);
            r_ovf     <= 1'b0;
            // The operand enters the field it is converted out of; the other field starts empty.
            r_work_bcd <= mode_i ? '0 : bcd_i;
            r_work_bin <= mode_i ? bin_i : '0;
            if (!mode_i && w_bad_digit) begin
              r_bcd_o <= bcd_i;
              r_bin_o <= '0;
              r_err   <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          r_work_bcd <= w_step_bcd;
          r_work_bin <= w_step_bin;
          r_ovf      <= r_ovf | w_step_out;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!r_mode) begin
            // The final iteration's values come from the step logic, not the work registers.
            r_bin_o <= w_step_bin;
            r_bcd_o <= r_cap_bcd;
            r_err   <= 1'b0;
          end else begin
            r_bcd_o <= w_step_bcd;
            r_bin_o <= r_cap_bin;
            r_err   <= r_ovf | w_step_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o = (r_state == S_IDLE);
  assign done_o  = (r_state == S_DONE);
  assign err_o   = r_err;
  assign bcd_o   = r_bcd_o;
  assign bin_o   = r_bin_o;

endmodule

// File: tb/tb_bcd_bin_codec.sv
// Directed bench for bcd_bin_codec with default parameters (4 digits, 14-bit binary).
module tb_bcd_bin_codec;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        mode_i;
  logic [15:0] bcd_i;
  logic [13:0] bin_i;
  logic        ready_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] bcd_o;
  logic [13:0] bin_o;

  int total = 0;
  int bad   = 0;
  int lat;

  bcd_bin_codec #(.DIGITS(4), .BIN_W(14)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (start_i),
    .mode_i  (mode_i),
    .bcd_i   (bcd_i),
    .bin_i   (bin_i),
    .ready_o (ready_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .bcd_o   (bcd_o),
    .bin_o   (bin_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one request, then step until done_o (bounded); lat counts cycles after the start edge.
  task automatic run(input logic m, input logic [15:0] b, input logic [13:0] n);
    start_i = 1'b1;
    mode_i  = m;
    bcd_i   = b;
    bin_i   = n;
    tick();
    start_i = 1'b0;
    bcd_i   = 16'h5555;
    bin_i   = 14'd3333;
    mode_i  = ~m;
    lat = 1;
    while (!done_o && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    reset_i = 1'b1;
    start_i = 1'b0;
    mode_i  = 1'b0;
    bcd_i   = '0;
    bin_i   = '0;
    tick();
    tick();
    reset_i = 1'b0;
    tick();
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_done",  32'(done_o),  32'd0);
    check("rst_err",   32'(err_o),   32'd0);
    check("rst_bcd",   32'(bcd_o),   32'd0);
    check("rst_bin",   32'(bin_o),   32'd0);

    run(1'b0, 16'h9999, 14'd0);
    check("b2n_9999_lat", 32'(lat),   32'd15);
    check("b2n_9999_bin", 32'(bin_o), 32'd9999);
    check("b2n_9999_bcd", 32'(bcd_o), 32'h9999);
    check("b2n_9999_err", 32'(err_o), 32'd0);
    tick();
    check("done_pulse", 32'(done_o),  32'd0);
    check("ready_back", 32'(ready_o), 32'd1);

    run(1'b0, 16'h0507, 14'd0);
    check("b2n_0507_bin", 32'(bin_o), 32'd507);
    tick();

    run(1'b1, 16'h0, 14'd1234);
    check("n2b_1234_lat", 32'(lat),   32'd15);
    check("n2b_1234_bcd", 32'(bcd_o), 32'h1234);
    check("n2b_1234_bin", 32'(bin_o), 32'd1234);
    check("n2b_1234_err", 32'(err_o), 32'd0);
    tick();

    run(1'b1, 16'h0, 14'd0);
    check("n2b_0_bcd", 32'(bcd_o), 32'h0);
    check("n2b_0_err", 32'(err_o), 32'd0);
    tick();

    run(1'b1, 16'h0, 14'd12345);
    check("n2b_12345_err", 32'(err_o), 32'd1);
    check("n2b_12345_bcd", 32'(bcd_o), 32'h2345);
    check("n2b_12345_bin", 32'(bin_o), 32'd12345);
    tick();

    run(1'b1, 16'h0, 14'd42);
    check("n2b_42_err", 32'(err_o), 32'd0);
    check("n2b_42_bcd", 32'(bcd_o), 32'h0042);
    tick();

    run(1'b1, 16'h0, 14'd10000);
    check("n2b_10000_err", 32'(err_o), 32'd1);
    check("n2b_10000_bcd", 32'(bcd_o), 32'h0000);
    tick();

    run(1'b1, 16'h0, 14'd16383);
    check("n2b_16383_err", 32'(err_o), 32'd1);
    check("n2b_16383_bcd", 32'(bcd_o), 32'h6383);
    tick();

    run(1'b0, 16'h12A4, 14'd0);
    check("inv_lat", 32'(lat),   32'd1);
    check("inv_err", 32'(err_o), 32'd1);
    check("inv_bin", 32'(bin_o), 32'd0);
    check("inv_bcd", 32'(bcd_o), 32'h12A4);
    tick();
    check("inv_ready", 32'(ready_o), 32'd1);

    run(1'b0, 16'hF000, 14'd0);
    check("inv_top_err", 32'(err_o), 32'd1);
    tick();
    run(1'b0, 16'h0042, 14'd0);
    check("b2n_42_err", 32'(err_o), 32'd0);
    check("b2n_42_bin", 32'(bin_o), 32'd42);
    tick();

    // start_i held high: starts at c=0,16,32 -> done at c=15,31,47.
    start_i = 1'b1;
    mode_i  = 1'b1;
    bin_i   = 14'd77;
    for (int c = 1; c <= 47; c++) begin
      tick();
      check("hold_done", 32'(done_o), 32'((c == 15) || (c == 31) || (c == 47)));
      check("hold_ready", 32'(ready_o), 32'((c == 16) || (c == 32)));
      if (c == 15) check("hold_bcd_77", 32'(bcd_o), 32'h0077);
      if (c == 31) check("hold_bcd_88", 32'(bcd_o), 32'h0088);
      if (c == 47) check("hold_bcd_99", 32'(bcd_o), 32'h0099);
      if (c == 3)  bin_i = 14'd88;
      if (c == 20) bin_i = 14'd99;
      if (c == 5 || c == 22) mode_i = 1'b0;
      if (c == 6 || c == 23) mode_i = 1'b1;
    end
    start_i = 1'b0;
    tick();
    check("hold_idle", 32'(ready_o), 32'd1);

    // Reset during SHIFT cycle 7 of a mode 1 run.
    start_i = 1'b1;
    mode_i  = 1'b1;
    bin_i   = 14'd4321;
    tick();
    start_i = 1'b0;
    for (int c = 2; c <= 7; c++) tick();
    check("pre_rst_ready", 32'(ready_o), 32'd0);
    reset_i = 1'b1;
    #1;
    check("mid_rst_ready", 32'(ready_o), 32'd1);
    check("mid_rst_done",  32'(done_o),  32'd0);
    check("mid_rst_err",   32'(err_o),   32'd0);
    check("mid_rst_bcd",   32'(bcd_o),   32'd0);
    check("mid_rst_bin",   32'(bin_o),   32'd0);
    tick();
    reset_i = 1'b0;
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done_o) lat++;
    end
    check("post_rst_no_done", 32'(lat), 32'd0);

    run(1'b1, 16'h0, 14'd9999);
    check("n2b_9999_lat", 32'(lat),   32'd15);
    check("n2b_9999_bcd", 32'(bcd_o), 32'h9999);
    check("n2b_9999_err", 32'(err_o), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
